// File: rtl/stego_lsb_engine.sv
// LSB steganography engine: embeds message bits into, or extracts them from, bit 0
// of every byte of cover words in the shared BRAM, owning the port only while busy.
module stego_lsb_engine #(
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_BYTES  = 4,
    parameter int DATA_WIDTH = NUM_BYTES * 8
) (
    input  logic                  pl_clk,
    input  logic                  pl_rst,
    input  logic                  start,
    input  logic                  op_extract,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] num_words,
    input  logic [31:0]           msg_data,
    input  logic                  msg_valid,
    output logic                  msg_ready,
    output logic [31:0]           ext_data,
    output logic                  ext_valid,
    input  logic                  ext_ready,
    output logic                  bram_mode,
    output logic [ADDR_WIDTH-1:0] pl_addr,
    output logic [DATA_WIDTH-1:0] pl_din,
    output logic [NUM_BYTES-1:0]  pl_we,
    input  logic [DATA_WIDTH-1:0] pl_dout,
    output logic                  busy,
    output logic                  done
);

    localparam int GROUP = 32 / NUM_BYTES;
    localparam int KW    = $clog2(GROUP);
    localparam logic [KW-1:0]         K_LAST = KW'(GROUP - 1);
    localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(NUM_BYTES);
    localparam logic [ADDR_WIDTH-1:0] ONE    = ADDR_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MSG  = 3'd1,
        S_RD   = 3'd2,
        S_WAIT = 3'd3,
        S_WR   = 3'd4,
        S_OUT  = 3'd5,
        S_DONE = 3'd6
    } state_t;

    // Replace bit 0 of each byte with the message bits of word slot kk.
    function automatic logic [DATA_WIDTH-1:0] embed_word(
        input logic [DATA_WIDTH-1:0] w,
        input logic [31:0]           m,
        input logic [KW-1:0]         kk
    );
        logic [DATA_WIDTH-1:0] r;
        int idx;
        r = w;
        for (int b = 0; b < NUM_BYTES; b++) begin
            idx = NUM_BYTES * int'(kk) + b;
            r[8*b] = m[idx];
        end
        return r;
    endfunction

    // Gather bit 0 of each byte into the accumulated message word at slot kk.
    function automatic logic [31:0] extract_bits(
        input logic [31:0]           s,
        input logic [DATA_WIDTH-1:0] w,
        input logic [KW-1:0]         kk
    );
        logic [31:0] r;
        int idx;
        r = s;
        for (int b = 0; b < NUM_BYTES; b++) begin
            idx = NUM_BYTES * int'(kk) + b;
            r[idx] = w[8*b];
        end
        return r;
    endfunction

    state_t                state;
    state_t                state_nxt;
    logic                  op;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [ADDR_WIDTH-1:0] num;
    logic [KW-1:0]         k;
    logic [31:0]           msg_reg;
    logic [31:0]           shift;
    logic [31:0]           shift_nxt;
    logic                  last;
    logic                  finished;

    // Job-progress flags and the next accumulated extract word.
    always_comb begin
        last      = ((cnt + ONE) == num);
        finished  = (cnt == num);
        shift_nxt = extract_bits(shift, pl_dout, k);
    end

    // Next-state and next-address selection.
    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        case (state)
            S_IDLE: begin
                if (start) begin
                    addr_nxt = base_addr;
                    if (num_words == {ADDR_WIDTH{1'b0}}) begin
                        state_nxt = S_DONE;
                    end else if (op_extract) begin
                        state_nxt = S_RD;
                    end else begin
                        state_nxt = S_MSG;
                    end
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_MSG: begin
                if (msg_valid) begin
                    state_nxt = S_RD;
                end else begin
                    state_nxt = S_MSG;
                end
            end
            S_RD: begin
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (op) begin
                    addr_nxt = addr + STRIDE;
                    if ((k == K_LAST) || last) begin
                        state_nxt = S_OUT;
                    end else begin
                        state_nxt = S_RD;
                    end
                end else begin
                    state_nxt = S_WR;
                end
            end
            S_WR: begin
                addr_nxt = addr + STRIDE;
                if (last) begin
                    state_nxt = S_DONE;
                end else if (k == K_LAST) begin
                    state_nxt = S_MSG;
                end else begin
                    state_nxt = S_RD;
                end
            end
            S_OUT: begin
                if (!ext_ready) begin
                    state_nxt = S_OUT;
                end else if (finished) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_RD;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs; outputs decode the state being entered.
    always_ff @(posedge pl_clk or posedge pl_rst) begin
        if (pl_rst) begin
            state     <= S_IDLE;
            op        <= 1'b0;
            addr      <= {ADDR_WIDTH{1'b0}};
            cnt       <= {ADDR_WIDTH{1'b0}};
            num       <= {ADDR_WIDTH{1'b0}};
            k         <= {KW{1'b0}};
            msg_reg   <= 32'h0000_0000;
            shift     <= 32'h0000_0000;
            ext_data  <= 32'h0000_0000;
            ext_valid <= 1'b0;
            msg_ready <= 1'b0;
            bram_mode <= 1'b0;
            pl_addr   <= {ADDR_WIDTH{1'b0}};
            pl_din    <= {DATA_WIDTH{1'b0}};
            pl_we     <= {NUM_BYTES{1'b0}};
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            addr      <= addr_nxt;
            bram_mode <= (state_nxt != S_IDLE) && (state_nxt != S_DONE);
            busy      <= (state_nxt != S_IDLE);
            done      <= (state_nxt == S_DONE);
            msg_ready <= (state_nxt == S_MSG);
            ext_valid <= (state_nxt == S_OUT);
            pl_we     <= (state_nxt == S_WR) ? {NUM_BYTES{1'b1}} : {NUM_BYTES{1'b0}};
            if (state_nxt == S_RD) begin
                pl_addr <= addr_nxt;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op    <= op_extract;
                        num   <= num_words;
                        cnt   <= {ADDR_WIDTH{1'b0}};
                        k     <= {KW{1'b0}};
                        shift <= 32'h0000_0000;
                    end
                end
                S_MSG: begin
                    if (msg_valid) begin
                        msg_reg <= msg_data;
                    end
                end
                S_WAIT: begin
                    if (op) begin
                        shift <= shift_nxt;
                        cnt   <= cnt + ONE;
                        k     <= k + {{(KW-1){1'b0}}, 1'b1};
                        if (state_nxt == S_OUT) begin
                            ext_data <= shift_nxt;
                        end
                    end else begin
                        pl_din <= embed_word(pl_dout, msg_reg, k);
                    end
                end
                S_WR: begin
                    cnt <= cnt + ONE;
                    k   <= k + {{(KW-1){1'b0}}, 1'b1};
                end
                S_OUT: begin
                    // Clearing on acceptance leaves unfilled bits of a partial group at 0.
                    if (ext_ready) begin
                        shift <= 32'h0000_0000;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stego_lsb_engine.sv
// Scoreboard bench for stego_lsb_engine: a behavioural BRAM, a message feeder and a
// monitor that checks every BRAM write and extracted word against queued expectations.
module tb_stego_lsb_engine;

    logic        clk;
    logic        rst;
    logic        start;
    logic        op_extract;
    logic [31:0] base_addr;
    logic [31:0] num_words;
    logic [31:0] msg_data;
    logic        msg_valid;
    logic        msg_ready;
    logic [31:0] ext_data;
    logic        ext_valid;
    logic        ext_ready;
    logic        bram_mode;
    logic [31:0] pl_addr;
    logic [31:0] pl_din;
    logic [3:0]  pl_we;
    logic [31:0] pl_dout;
    logic        busy;
    logic        done;

    logic        ps_we;
    logic [31:0] ps_addr;
    logic [31:0] ps_data;
    logic [31:0] mem [0:255];

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [31:0] ext_q[$];
    logic [31:0] msg_q[$];

    stego_lsb_engine #(.ADDR_WIDTH(32), .NUM_BYTES(4), .DATA_WIDTH(32)) dut (
        .pl_clk(clk), .pl_rst(rst), .start(start), .op_extract(op_extract),
        .base_addr(base_addr), .num_words(num_words),
        .msg_data(msg_data), .msg_valid(msg_valid), .msg_ready(msg_ready),
        .ext_data(ext_data), .ext_valid(ext_valid), .ext_ready(ext_ready),
        .bram_mode(bram_mode), .pl_addr(pl_addr), .pl_din(pl_din), .pl_we(pl_we),
        .pl_dout(pl_dout), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM: synchronous read, byte writes from PL in PL mode, PS preload otherwise.
    always @(posedge clk) begin
        if (bram_mode) begin
            pl_dout <= mem[pl_addr[9:2]];
            for (int b = 0; b < 4; b++) begin
                if (pl_we[b]) mem[pl_addr[9:2]][8*b +: 8] <= pl_din[8*b +: 8];
            end
        end else if (ps_we) begin
            mem[ps_addr[9:2]] <= ps_data;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare each BRAM write and each accepted extract word with the scoreboard.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (pl_we != 4'h0) begin
            if (wr_addr_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_write: got addr %h data %h, expected none", pl_addr, pl_din);
            end else begin
                check("wr_addr", pl_addr, wr_addr_q.pop_front());
                check("wr_data", pl_din, wr_data_q.pop_front());
                check("wr_we", {28'h0, pl_we}, 32'hF);
            end
        end
        if (ext_valid && ext_ready) begin
            if (ext_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_ext: got %h, expected none", ext_data);
            end else begin
                check("ext_data", ext_data, ext_q.pop_front());
            end
        end
    end

    // Message source: present the queue head, pop it after a handshake edge.
    initial begin
        logic hs;
        msg_valid = 1'b0;
        msg_data  = 32'h0;
        forever begin
            @(negedge clk);
            hs = msg_valid && msg_ready;
            @(posedge clk);
            #1;
            if (hs && msg_q.size() > 0) void'(msg_q.pop_front());
            msg_valid = (msg_q.size() > 0);
            msg_data  = (msg_q.size() > 0) ? msg_q[0] : 32'h0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [31:0] base, input int n, input logic [31:0] val);
        for (int i = 0; i < n; i++) begin
            ps_we   = 1'b1;
            ps_addr = base + 32'(4 * i);
            ps_data = val;
            tick();
        end
        ps_we = 1'b0;
    endtask

    task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
        wr_addr_q.push_back(a);
        wr_data_q.push_back(d);
    endtask

    task automatic run_job(input logic op, input logic [31:0] base, input logic [31:0] num);
        tick();
        start      = 1'b1;
        op_extract = op;
        base_addr  = base;
        num_words  = num;
        tick();
        start = 1'b0;
    endtask

    // Wait for the done pulse, counting PL-mode cycles; also checks done lasts one cycle.
    task automatic wait_done(input string name, input int limit, output int mode_cyc);
        bit seen;
        seen = 1'b0;
        mode_cyc = 0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (bram_mode) mode_cyc++;
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: got no done, expected done within %0d cycles", name, limit);
        end else begin
            @(negedge clk);
            check({name, "_done_width"}, {31'h0, done}, 32'h0);
        end
    endtask

    logic [31:0] t1 [0:7];
    int mc;
    int dc0;
    bit hit;

    initial begin
        t1[0] = 32'h0100_0000; t1[1] = 32'h0001_0101; t1[2] = 32'h0001_0100; t1[3] = 32'h0001_0001;
        t1[4] = 32'h0001_0000; t1[5] = 32'h0000_0101; t1[6] = 32'h0000_0100; t1[7] = 32'h0000_0001;
        rst = 1'b1; start = 1'b0; op_extract = 1'b0; base_addr = 32'h0; num_words = 32'h0;
        ext_ready = 1'b1; ps_we = 1'b0; ps_addr = 32'h0; ps_data = 32'h0;
        tick();
        @(negedge clk);
        check("rst_bram_mode", {31'h0, bram_mode}, 32'h0);
        check("rst_pl_addr", pl_addr, 32'h0);
        check("rst_pl_din", pl_din, 32'h0);
        check("rst_pl_we", {28'h0, pl_we}, 32'h0);
        check("rst_handshakes", {29'h0, msg_ready, ext_valid, busy}, 32'h0);
        check("rst_ext_data", ext_data, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        tick();
        rst = 1'b0;

        // Embed 0x12345678 into zero cover words at 0x0.
        preload(32'h0, 8, 32'h0);
        for (int i = 0; i < 8; i++) exp_wr(32'(4 * i), t1[i]);
        msg_q.push_back(32'h1234_5678);
        dc0 = done_cnt;
        run_job(1'b0, 32'h0, 32'd8);
        wait_done("embed1", 100, mc);
        check("embed1_mode_cycles", 32'(mc), 32'd25);
        check("embed1_done_count", 32'(done_cnt - dc0), 32'd1);
        check("embed1_wr_left", 32'(wr_addr_q.size()), 32'd0);

        // Extract it back while the consumer stalls for 5 cycles.
        ext_q.push_back(32'h1234_5678);
        ext_ready = 1'b0;
        run_job(1'b1, 32'h0, 32'd8);
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk);
            if (ext_valid) hit = 1'b1;
        end
        check("ext1_valid_seen", {31'h0, hit}, 32'h1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check("ext1_hold_valid", {31'h0, ext_valid}, 32'h1);
            check("ext1_hold_data", ext_data, 32'h1234_5678);
            check("ext1_hold_addr", pl_addr, 32'h0000_001C);
            check("ext1_hold_we", {28'h0, pl_we}, 32'h0);
        end
        tick();
        ext_ready = 1'b1;
        wait_done("ext1", 40, mc);
        check("ext1_left", 32'(ext_q.size()), 32'd0);

        // Embed zero message into all-ones cover; sentinel at 0x20 must survive.
        preload(32'h0, 8, 32'hFFFF_FFFF);
        preload(32'h20, 1, 32'hDEAD_BEEF);
        for (int i = 0; i < 8; i++) exp_wr(32'(4 * i), 32'hFEFE_FEFE);
        msg_q.push_back(32'h0);
        run_job(1'b0, 32'h0, 32'd8);
        wait_done("embed2", 100, mc);
        check("embed2_sentinel", mem[8], 32'hDEAD_BEEF);
        check("embed2_wr_left", 32'(wr_addr_q.size()), 32'd0);

        // Ten words: a full group then a partial group of two.
        preload(32'h100, 10, 32'h8080_8080);
        for (int i = 0; i < 8; i++) exp_wr(32'h100 + 32'(4 * i), 32'h8180_8180);
        exp_wr(32'h120, 32'h8181_8181);
        exp_wr(32'h124, 32'h8080_8080);
        msg_q.push_back(32'hAAAA_AAAA);
        msg_q.push_back(32'h0000_000F);
        run_job(1'b0, 32'h100, 32'd10);
        wait_done("embed10", 150, mc);
        check("embed10_mode_cycles", 32'(mc), 32'd32);
        ext_q.push_back(32'hAAAA_AAAA);
        ext_q.push_back(32'h0000_000F);
        run_job(1'b1, 32'h100, 32'd10);
        wait_done("ext10", 100, mc);
        check("ext10_mode_cycles", 32'(mc), 32'd22);
        check("ext10_left", 32'(ext_q.size()), 32'd0);

        // Zero-length job: done the cycle after start is taken, PS keeps the BRAM.
        dc0 = done_cnt;
        run_job(1'b0, 32'h0, 32'd0);
        @(negedge clk);
        check("zero_done", {31'h0, done}, 32'h1);
        check("zero_mode", {31'h0, bram_mode}, 32'h0);
        check("zero_we", {28'h0, pl_we}, 32'h0);
        @(negedge clk);
        check("zero_done_drop", {30'h0, done, busy}, 32'h0);
        check("zero_done_count", 32'(done_cnt - dc0), 32'd1);

        // Reset during the write of word 3, then a clean job from the same base.
        preload(32'h200, 8, 32'h0);
        exp_wr(32'h200, 32'h0000_0001);
        exp_wr(32'h204, 32'h0000_0100);
        exp_wr(32'h208, 32'h0000_0101);
        msg_q.push_back(32'h8765_4321);
        dc0 = done_cnt;
        run_job(1'b0, 32'h200, 32'd8);
        hit = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            if (pl_we != 4'h0 && pl_addr == 32'h20C) hit = 1'b1;
            else tick();
        end
        check("abort_wr3_seen", {31'h0, hit}, 32'h1);
        rst = 1'b1;
        #1;
        check("abort_outputs", {29'h0, bram_mode, |pl_we, busy}, 32'h0);
        check("abort_wr_left", 32'(wr_addr_q.size()), 32'd0);
        tick();
        rst = 1'b0;
        check("abort_no_done", 32'(done_cnt - dc0), 32'd0);
        exp_wr(32'h200, 32'h0101_0001);
        exp_wr(32'h204, 32'h0101_0000);
        exp_wr(32'h208, 32'h0100_0101);
        exp_wr(32'h20C, 32'h0100_0100);
        msg_q.push_back(32'h0000_ABCD);
        run_job(1'b0, 32'h200, 32'd4);
        wait_done("rerun", 60, mc);
        check("rerun_wr_left", 32'(wr_addr_q.size()), 32'd0);
        check("rerun_mem3", mem[131], 32'h0100_0100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule
